// File: rtl/inst_buffer_pkg.sv
// Shared front-end pipeline types: fetch/decode widths and the instruction-buffer entry.
// Pure declarations, no logic or latency; no flow control of its own.
// Used by inst_buffer and its storage array.
package inst_buffer_pkg;

    localparam int FETCH_WIDTH  = 4;
    localparam int DECODE_WIDTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } InstBufEntrySt;

endpackage

// File: rtl/inst_buffer_ram.sv
// DEPTH-entry register array for the instruction buffer, multi-write / multi-read.
// Writes land on the clock edge; reads are combinational from stored state.
// No backpressure; callers guarantee distinct write indices within a cycle.
module inst_buffer_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WPORTS = 4,
    parameter int RPORTS = 2,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic          [WPORTS-1:0]       wr_en,
    input  logic          [WPORTS-1:0][IW-1:0] wr_idx,
    input  InstBufEntrySt [WPORTS-1:0]       wr_dat,
    input  logic          [RPORTS-1:0][IW-1:0] rd_idx,
    output InstBufEntrySt [RPORTS-1:0]       rd_dat
);

    InstBufEntrySt mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int w = 0; w < WPORTS; w++) begin
            if (wr_en[w]) begin
                mem[wr_idx[w]] <= wr_dat[w];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RPORTS; r++) begin
            rd_dat[r] = mem[rd_idx[r]];
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Instruction queue between fetch and decode; strict program order, flushable.
// Push visible on dec_* one cycle later (no bypass); outputs are combinational reads.
// fetch_ready_o only from registered count (needs room for a full group); decode pops all valid slots.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int FETCH_WIDTH  = inst_buffer_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = inst_buffer_pkg::DECODE_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    input  logic                               fetch_valid_i,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]   fetch_cnt_i,
    input  logic [FETCH_WIDTH*32-1:0]          fetch_pc_i,
    input  logic [FETCH_WIDTH*32-1:0]          fetch_inst_i,
    output logic                               fetch_ready_o,
    output logic [DECODE_WIDTH-1:0]            dec_valid_o,
    output logic [DECODE_WIDTH*32-1:0]         dec_pc_o,
    output logic [DECODE_WIDTH*32-1:0]         dec_inst_o,
    input  logic                               dec_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int FCW = $clog2(FETCH_WIDTH+1);

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] npush, npop;
    logic          push, pop;

    logic          [FETCH_WIDTH-1:0]          wr_en;
    logic          [FETCH_WIDTH-1:0][PW-1:0]  wr_idx;
    InstBufEntrySt [FETCH_WIDTH-1:0]          wr_dat;
    logic          [DECODE_WIDTH-1:0][PW-1:0] rd_idx;
    InstBufEntrySt [DECODE_WIDTH-1:0]         rd_dat;

    assign fetch_ready_o = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);
    assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
    assign pop           = dec_ready_i && !flush_i;
    assign npush         = push ? CW'(fetch_cnt_i) : '0;
    assign npop          = !pop ? '0 :
                           (count < CW'(DECODE_WIDTH)) ? count : CW'(DECODE_WIDTH);

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_en[i]       = push && (FCW'(i) < fetch_cnt_i);
            wr_idx[i]      = wr_ptr + PW'(i);
            wr_dat[i].pc   = fetch_pc_i[i*32 +: 32];
            wr_dat[i].inst = fetch_inst_i[i*32 +: 32];
        end
    end

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            rd_idx[i]           = rd_ptr + PW'(i);
            dec_valid_o[i]      = count > CW'(i);
            dec_pc_o[i*32 +: 32]   = rd_dat[i].pc;
            dec_inst_o[i*32 +: 32] = rd_dat[i].inst;
        end
    end

    assign count_o = count;

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(npop);
            wr_ptr <= wr_ptr + PW'(npush);
            count  <= count + npush - npop;
        end
    end

    inst_buffer_ram #(
        .DEPTH  (DEPTH),
        .WPORTS (FETCH_WIDTH),
        .RPORTS (DECODE_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_dat (wr_dat),
        .rd_idx (rd_idx),
        .rd_dat (rd_dat)
    );

    cnt_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
        fetch_valid_i |-> (fetch_cnt_i <= FCW'(FETCH_WIDTH)));

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: expected entries queued on accepted push, compared at the head.
module tb_inst_buffer;

    localparam int DEPTH = 16;
    localparam int FW    = 4;
    localparam int DW    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic              fetch_valid_i;
    logic [2:0]        fetch_cnt_i;
    logic [FW*32-1:0]  fetch_pc_i;
    logic [FW*32-1:0]  fetch_inst_i;
    logic              fetch_ready_o;
    logic [DW-1:0]     dec_valid_o;
    logic [DW*32-1:0]  dec_pc_o;
    logic [DW*32-1:0]  dec_inst_o;
    logic              dec_ready_i;
    logic [4:0]        count_o;

    ent_t mq[$];
    int   checks = 0;
    int   errors = 0;

    inst_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_cnt_i   (fetch_cnt_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_inst_i  (fetch_inst_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_pc_o      (dec_pc_o),
        .dec_inst_o    (dec_inst_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle, updates the scoreboard with the behaviour the buffer must show, samples #1 after the edge.
    task automatic step(input bit v, input int cnt, input logic [31:0] base, input bit rdy, input bit fl);
        bit acc;
        int np;
        fetch_valid_i = v;
        fetch_cnt_i   = 3'(cnt);
        dec_ready_i   = rdy;
        flush_i       = fl;
        for (int k = 0; k < FW; k++) begin
            fetch_pc_i[k*32 +: 32]   = base + 32'(4 * k);
            fetch_inst_i[k*32 +: 32] = $urandom;
        end
        acc = v && (mq.size() <= DEPTH - FW) && !fl;
        np  = (rdy && !fl) ? ((mq.size() < DW) ? mq.size() : DW) : 0;
        if (fl) begin
            mq.delete();
        end else begin
            for (int k = 0; k < np; k++) void'(mq.pop_front());
            if (acc) begin
                for (int k = 0; k < cnt; k++) begin
                    ent_t e;
                    e.pc   = fetch_pc_i[k*32 +: 32];
                    e.inst = fetch_inst_i[k*32 +: 32];
                    mq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
        fetch_cnt_i   = '0;
        dec_ready_i   = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        checks++;
        if (dec_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", dec_valid_o); end
        checks++;
        if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", fetch_ready_o); end
    endtask

    task automatic test_single_push();
        step(1, 3, 32'h1c00_0000, 0, 0);
        checks++;
        if (count_o !== 5'd3) begin errors++; $display("FAIL single_count got %0d want 3", count_o); end
        checks++;
        if (dec_valid_o !== 2'b11) begin errors++; $display("FAIL single_valid got %b want 11", dec_valid_o); end
        checks++;
        if (dec_pc_o !== {32'h1c00_0004, 32'h1c00_0000}) begin
            errors++; $display("FAIL single_pc got %h want 1c0000041c000000", dec_pc_o);
        end
        checks++;
        if (dec_inst_o !== {mq[1].inst, mq[0].inst}) begin
            errors++; $display("FAIL single_inst got %h want %h", dec_inst_o, {mq[1].inst, mq[0].inst});
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (count_o !== 5'd1) begin errors++; $display("FAIL single_pop_count got %0d want 1", count_o); end
        checks++;
        if (dec_valid_o !== 2'b01 || dec_pc_o[31:0] !== 32'h1c00_0008) begin
            errors++; $display("FAIL single_pop_head got v=%b pc=%h want v=01 pc=1c000008", dec_valid_o, dec_pc_o[31:0]);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (count_o !== 5'd0) begin errors++; $display("FAIL single_drain got %0d want 0", count_o); end
    endtask

    // Pops until empty, checking occupancy and both head slots every cycle.
    task automatic drain(input string tag);
        int guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            checks++;
            if (count_o !== 5'(mq.size())) begin
                errors++; $display("FAIL %s_count got %0d want %0d", tag, count_o, mq.size());
            end
            for (int i = 0; i < DW; i++) begin
                if (i < mq.size()) begin
                    checks++;
                    if (dec_valid_o[i] !== 1'b1 || dec_pc_o[i*32 +: 32] !== mq[i].pc ||
                        dec_inst_o[i*32 +: 32] !== mq[i].inst) begin
                        errors++;
                        $display("FAIL %s_slot%0d got v=%b pc=%h inst=%h want pc=%h inst=%h", tag, i,
                                 dec_valid_o[i], dec_pc_o[i*32 +: 32], dec_inst_o[i*32 +: 32], mq[i].pc, mq[i].inst);
                    end
                end
            end
            step(0, 0, 0, 1, 0);
            guard++;
        end
        checks++;
        if (mq.size() != 0 || count_o !== 5'd0 || dec_valid_o !== 2'b00) begin
            errors++; $display("FAIL %s_empty got count=%0d v=%b want 0/00", tag, count_o, dec_valid_o);
        end
    endtask

    task automatic test_fill();
        logic [31:0] head_pc;
        for (int g = 0; g < 4; g++) begin
            step(1, 4, 32'h1c00_0100 + 32'(16 * g), 0, 0);
            if (g == 2) begin
                checks++;
                if (count_o !== 5'd12 || fetch_ready_o !== 1'b1) begin
                    errors++; $display("FAIL fill_12 got count=%0d rdy=%b want 12/1", count_o, fetch_ready_o);
                end
            end
        end
        checks++;
        if (count_o !== 5'd16 || fetch_ready_o !== 1'b0) begin
            errors++; $display("FAIL fill_16 got count=%0d rdy=%b want 16/0", count_o, fetch_ready_o);
        end
        head_pc = dec_pc_o[31:0];
        step(1, 4, 32'h1c00_0f00, 0, 0);
        checks++;
        if (count_o !== 5'd16 || dec_pc_o[31:0] !== head_pc || head_pc !== 32'h1c00_0100) begin
            errors++; $display("FAIL fill_reject got count=%0d pc=%h want 16 pc=1c000100", count_o, dec_pc_o[31:0]);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 1, 32'h1c00_0140, 0, 0);
        checks++;
        if (count_o !== 5'd13 || fetch_ready_o !== 1'b0) begin
            errors++; $display("FAIL fill_13 got count=%0d rdy=%b want 13/0", count_o, fetch_ready_o);
        end
        drain("fill");
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 3; g++) step(1, 4, 32'h1c00_0200 + 32'(16 * g), 0, 0);
        checks++;
        if (count_o !== 5'd12) begin errors++; $display("FAIL b2b_pre got %0d want 12", count_o); end
        step(1, 4, 32'h1c00_0230, 1, 0);
        checks++;
        if (count_o !== 5'd14) begin errors++; $display("FAIL b2b_count got %0d want 14", count_o); end
        checks++;
        if (dec_pc_o[31:0] !== 32'h1c00_0208) begin
            errors++; $display("FAIL b2b_head got %h want 1c000208", dec_pc_o[31:0]);
        end
        drain("wrap");
    endtask

    task automatic test_flush();
        step(1, 4, 32'h1c00_0300, 0, 0);
        step(1, 4, 32'h1c00_0310, 0, 0);
        step(1, 1, 32'h1c00_0320, 0, 0);
        checks++;
        if (count_o !== 5'd9) begin errors++; $display("FAIL flush_pre got %0d want 9", count_o); end
        step(1, 4, 32'h1c00_0400, 1, 1);
        checks++;
        if (count_o !== 5'd0 || dec_valid_o !== 2'b00) begin
            errors++; $display("FAIL flush_clear got count=%0d v=%b want 0/00", count_o, dec_valid_o);
        end
        step(1, 1, 32'h1c00_1000, 0, 0);
        checks++;
        if (count_o !== 5'd1 || dec_valid_o !== 2'b01 || dec_pc_o[31:0] !== 32'h1c00_1000) begin
            errors++; $display("FAIL flush_repush got count=%0d v=%b pc=%h want 1/01/1c001000",
                               count_o, dec_valid_o, dec_pc_o[31:0]);
        end
        drain("flush");
    endtask

    task automatic test_async_reset();
        step(1, 4, 32'h1c00_0500, 0, 0);
        step(1, 3, 32'h1c00_0510, 0, 0);
        checks++;
        if (count_o !== 5'd7) begin errors++; $display("FAIL areset_pre got %0d want 7", count_o); end
        #2;
        rst_n = 1'b0;
        mq.delete();
        #1;
        checks++;
        if (count_o !== 5'd0 || dec_valid_o !== 2'b00 || fetch_ready_o !== 1'b1) begin
            errors++; $display("FAIL areset_now got count=%0d v=%b rdy=%b want 0/00/1",
                               count_o, dec_valid_o, fetch_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 32'h1c00_0600, 0, 0);
        checks++;
        if (count_o !== 5'd1 || dec_pc_o[31:0] !== 32'h1c00_0600) begin
            errors++; $display("FAIL areset_push got count=%0d pc=%h want 1/1c000600", count_o, dec_pc_o[31:0]);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_cnt_i   = '0;
        fetch_pc_i    = '0;
        fetch_inst_i  = '0;
        dec_ready_i   = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Multi-entry instruction queue directly upstream of the decoder.
- Absorbs fetch-group bursts of up to FETCH_WIDTH instructions per cycle.
- Presents up to DECODE_WIDTH oldest instructions per cycle, in program order, to decode.
- Decouples fetch stalls from decode stalls; cleared by a pipeline flush (branch redirect or exception).

Parameters:
- DEPTH, 16: number of entries; must be a power of two and >= FETCH_WIDTH + DECODE_WIDTH.
- FETCH_WIDTH, 4: maximum instructions written per cycle.
- DECODE_WIDTH, 2: instructions presented to decode per cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all contents.
- fetch_valid_i  in  1  fetch group valid.
- fetch_cnt_i  in  $clog2(FETCH_WIDTH+1)  number of valid instructions in group; slots 0..cnt-1 are valid.
- fetch_pc_i  in  FETCH_WIDTH*32  per-slot PC; slot 0 is the oldest.
- fetch_inst_i  in  FETCH_WIDTH*32  per-slot instruction word.
- fetch_ready_o  out  1  buffer can take a full fetch group.
- dec_valid_o  out  DECODE_WIDTH  per-slot valid toward decode; thermometer-coded.
- dec_pc_o  out  DECODE_WIDTH*32  PC of the i-th oldest entry.
- dec_inst_o  out  DECODE_WIDTH*32  instruction of the i-th oldest entry.
- dec_ready_i  in  1  decoder consumes all currently valid slots this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr, wr_ptr and count clear to 0.
  - Consequently dec_valid_o = 0, count_o = 0, fetch_ready_o = 1.
  - Storage array is not reset.
- fetch_ready_o = (DEPTH - count) >= FETCH_WIDTH.
  - Combinational from the registered count only; it does not credit same-cycle pops.
  - It is conservative and has no combinational path from dec_ready_i.
- Push:
  - Occurs when fetch_valid_i && fetch_ready_o && !flush_i.
  - Writes slots 0..fetch_cnt_i-1 to entries wr_ptr..wr_ptr+cnt-1, modulo DEPTH.
  - wr_ptr advances by cnt.
  - fetch_cnt_i = 0 with valid high is a no-op.
  - fetch_cnt_i > FETCH_WIDTH is illegal; an assertion must flag it.
- Outputs toward decode:
  - dec_valid_o[i] = (count > i).
  - dec_pc_o / dec_inst_o slot i come from entry (rd_ptr + i) mod DEPTH.
  - Outputs are combinational reads of registered storage.
  - Data on invalid slots is don't-care.
- Pop:
  - Occurs when dec_ready_i && !flush_i.
  - Removes npop = min(count, DECODE_WIDTH) entries; rd_ptr advances by npop.
  - dec_ready_i with count = 0 is a no-op.
- Count update: count_next = count + npush - npop.
  - Simultaneous push and pop are both honoured in the same cycle.
- Latency: an instruction pushed in cycle N is visible on dec_* no earlier than cycle N+1. There is no bypass.
- Flush:
  - Synchronous. In the next cycle rd_ptr = wr_ptr = count = 0.
  - Push and pop presented in the flush cycle are ignored.
  - Flush has priority over reset-free operation only; rst_n always dominates.
- Pointer and count widths:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH+1) bits and never exceeds DEPTH by construction.
- Ordering: strict FIFO; slot 0 of decode is always the oldest entry.
- Reset mid-operation: all state returns to its reset value immediately (asynchronous); the first push is accepted in the first clock after deassertion.

Decomposition:
- Shared pipeline package (alongside the decoder control typedefs):
  - FETCH_WIDTH and DECODE_WIDTH constants.
  - InstBufEntrySt {logic [31:0] pc; logic [31:0] inst;}.
  - Port arrays are expressed as packed arrays of this struct.
- One natural sub-module: inst_buffer_ram.
  - DEPTH x InstBufEntrySt register array.
  - FETCH_WIDTH write ports with per-port enable and index.
  - DECODE_WIDTH read ports with index.
- Pointer, count and handshake logic stays in inst_buffer.

Test Plan:
- Reset, then idle:
  - count_o = 0, dec_valid_o = 2'b00, fetch_ready_o = 1.
- Single push of cnt = 3 (PCs 0x1c000000/04/08), dec_ready_i = 0:
  - Next cycle count_o = 3, dec_valid_o = 2'b11, dec_pc_o = {0x1c000004, 0x1c000000}.
  - Then dec_ready_i = 1 for one cycle gives count_o = 1 and dec_pc_o slot0 = 0x1c000008.
- Fill:
  - Four pushes of cnt = 4 with no pops: count_o = 16.
  - fetch_ready_o drops to 0 once count_o = 13.
  - A further fetch_valid_i is not accepted: count stays 16 and contents are unchanged.
- Simultaneous push and pop at count = 12:
  - cnt = 4 push with dec_ready_i = 1 gives count_o = 14 next cycle, order preserved.
  - Wrap-around past entry 15 is verified by checking sequential PCs.
- Flush at count = 9 with same-cycle push (cnt = 4) and pop:
  - Next cycle count_o = 0, dec_valid_o = 0.
  - The subsequent push of PC 0x1c001000 appears at slot0.
- Asynchronous reset asserted mid-cycle while count = 7:
  - Outputs go to reset values without a clock edge.
  - After release, a push of cnt = 1 yields count_o = 1.
